// File: rtl/ac_meas_pkg.sv
// Shared measurement types and sizing for the lock-in detector.
// Read by ac_lockin_detector, lockin_mac_lane and ac_lockin_detector_if.
package ac_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    DRAIN,
    DONE
  } meas_state_t;

  localparam int ADC_W_DEF     = 12;
  localparam int REF_W_DEF     = 16;
  localparam int LOG2N_MAX_DEF = 16;
  localparam int LOG2N_W       = 5;

  // Room for 2^log2n_max full-scale products without overflow.
  function automatic int acc_width(input int adc_w, input int ref_w, input int log2n_max);
    return adc_w + ref_w + log2n_max;
  endfunction

endpackage

// File: rtl/ac_lockin_detector_if.sv
// Control, sample and result bus of the lock-in detector.
// master = driving side (ADC front end / register bank), slave = detector.
import ac_meas_pkg::*;

interface ac_lockin_detector_if #(
  parameter int ADC_W = ADC_W_DEF,
  parameter int REF_W = REF_W_DEF
);
  logic                            start;
  logic [LOG2N_W-1:0]              log2n;
  logic                            sample_valid;
  logic signed [ADC_W-1:0]         sample;
  logic signed [REF_W-1:0]         cos_ref;
  logic signed [REF_W-1:0]         sin_ref;
  logic                            busy;
  logic                            result_valid;
  logic                            result_ready;
  logic signed [ADC_W+REF_W-1:0]   i_avg;
  logic signed [ADC_W+REF_W-1:0]   q_avg;
  logic signed [ADC_W-1:0]         dc_avg;

  modport master (
    output start, log2n, sample_valid, sample, cos_ref, sin_ref, result_ready,
    input  busy, result_valid, i_avg, q_avg, dc_avg
  );

  modport slave (
    input  start, log2n, sample_valid, sample, cos_ref, sin_ref, result_ready,
    output busy, result_valid, i_avg, q_avg, dc_avg
  );

endinterface

// File: rtl/lockin_mac_lane.sv
// One correlation lane: register a*b, accumulate one cycle later,
// and load the floor-shifted average into a held output register.
import ac_meas_pkg::*;

module lockin_mac_lane #(
  parameter int A_W   = ADC_W_DEF,
  parameter int B_W   = REF_W_DEF,
  parameter int ACC_W = acc_width(ADC_W_DEF, REF_W_DEF, LOG2N_MAX_DEF),
  parameter int AVG_W = A_W + B_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic                    load,
  input  logic [LOG2N_W-1:0]      shamt,
  output logic signed [AVG_W-1:0] avg
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod_q;
  logic                    prod_valid_q;
  logic signed [ACC_W-1:0] acc_q;

  // Stage 1 product, stage 2 accumulate; avg only moves on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      acc_q        <= '0;
      avg          <= '0;
    end else begin
      if (clear) begin
        prod_valid_q <= 1'b0;
        acc_q        <= '0;
      end else begin
        prod_valid_q <= en;
        if (en)
          prod_q <= P_W'(a) * P_W'(b);
        if (prod_valid_q)
          acc_q <= acc_q + ACC_W'(prod_q);
      end
      if (load)
        avg <= AVG_W'(acc_q >>> shamt);
    end
  end

endmodule

// File: rtl/ac_lockin_detector.sv
// Lock-in I/Q detector: correlates 2^n samples with cos/sin and averages.
// Optional DC-average lane is built when AC_LOCKIN_DC_EN is defined.
import ac_meas_pkg::*;

module ac_lockin_detector #(
  parameter int ADC_W     = ADC_W_DEF,
  parameter int REF_W     = REF_W_DEF,
  parameter int LOG2N_MAX = LOG2N_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  ac_lockin_detector_if.slave bus
);

  localparam int ACC_W = acc_width(ADC_W, REF_W, LOG2N_MAX);
  localparam int CNT_W = LOG2N_MAX + 1;

  meas_state_t        state_q;
  logic [LOG2N_W-1:0] n_q;
  logic [CNT_W-1:0]   count_q;
  logic               drain_wait_q;
  logic               result_valid_q;
  logic               clear;
  logic               target_hit;
  logic               accept;
  logic               load;

  assign clear      = (state_q == IDLE) && bus.start;
  assign target_hit = (count_q == (CNT_W'(1) << n_q));
  assign accept     = (state_q == ACQ) && bus.sample_valid && !target_hit;
  assign load       = (state_q == DRAIN) && drain_wait_q;

  // DRAIN spends two edges so the final product is accumulated before load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      n_q            <= '0;
      count_q        <= '0;
      drain_wait_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          n_q     <= (bus.log2n > LOG2N_W'(LOG2N_MAX)) ? LOG2N_W'(LOG2N_MAX) : bus.log2n;
          count_q <= '0;
          state_q <= ACQ;
        end
        ACQ: if (target_hit) begin
          drain_wait_q <= 1'b0;
          state_q      <= DRAIN;
        end else if (bus.sample_valid) begin
          count_q <= count_q + 1'b1;
        end
        DRAIN: if (!drain_wait_q) begin
          drain_wait_q <= 1'b1;
        end else begin
          result_valid_q <= 1'b1;
          state_q        <= DONE;
        end
        DONE: if (bus.result_ready) begin
          result_valid_q <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state_q == ACQ) || (state_q == DRAIN);
  assign bus.result_valid = result_valid_q;

  lockin_mac_lane #(.A_W(ADC_W), .B_W(REF_W), .ACC_W(ACC_W)) i_lane (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(accept),
    .a(bus.sample), .b(bus.cos_ref), .load(load), .shamt(n_q), .avg(bus.i_avg)
  );

  lockin_mac_lane #(.A_W(ADC_W), .B_W(REF_W), .ACC_W(ACC_W)) q_lane (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(accept),
    .a(bus.sample), .b(bus.sin_ref), .load(load), .shamt(n_q), .avg(bus.q_avg)
  );

`ifdef AC_LOCKIN_DC_EN
  // Reference of +1 turns the lane into a plain sample average.
  lockin_mac_lane #(.A_W(ADC_W), .B_W(2), .ACC_W(ACC_W), .AVG_W(ADC_W)) dc_lane (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(accept),
    .a(bus.sample), .b(2'sb01), .load(load), .shamt(n_q), .avg(bus.dc_avg)
  );
`else
  assign bus.dc_avg = '0;
`endif

endmodule

// File: tb/tb_ac_lockin_detector.sv
// Self-checking bench for ac_lockin_detector against an arithmetic I/Q model.
// Expects dc_avg results only when AC_LOCKIN_DC_EN is defined.
import ac_meas_pkg::*;

module tb_ac_lockin_detector;

  localparam int ADC_W     = 12;
  localparam int REF_W     = 16;
  localparam int LOG2N_MAX = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   samp_q[$];
  int   cos_q[$];
  int   sin_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ac_lockin_detector_if #(.ADC_W(ADC_W), .REF_W(REF_W)) bus ();

  ac_lockin_detector #(.ADC_W(ADC_W), .REF_W(REF_W), .LOG2N_MAX(LOG2N_MAX)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check_output(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Average rounded toward minus infinity, computed by integer division.
  function automatic longint floor_avg(input longint sum, input int n);
    longint d;
    longint q;
    d = longint'(1) << n;
    q = sum / d;
    if ((sum % d) != 0 && sum < 0)
      q = q - 1;
    return q;
  endfunction

  task automatic fill_const(input int count, input int s, input int c, input int sn);
    for (int k = 0; k < count; k++) begin
      samp_q.push_back(s);
      cos_q.push_back(c);
      sin_q.push_back(sn);
    end
  endtask

  task automatic fill_random(input int count);
    for (int k = 0; k < count; k++) begin
      samp_q.push_back(int'($urandom_range(4095)) - 2048);
      cos_q.push_back(int'($urandom_range(65535)) - 32768);
      sin_q.push_back(int'($urandom_range(65535)) - 32768);
    end
  endtask

  task automatic clear_queues();
    samp_q.delete();
    cos_q.delete();
    sin_q.delete();
  endtask

  task automatic start_acq(input int l2n);
    bus.log2n = LOG2N_W'(l2n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic consume(input string tag);
    bus.result_ready = 1'b1;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    check_output({tag, "_rv_drop"}, bus.result_valid, 0);
    check_output({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  // Runs one acquisition over the queued triples and checks latency and results.
  task automatic apply_stimulus(input string tag, input int l2n, input bit gapped,
                                input bit poke_start);
    int     n;
    int     need;
    int     last_cap;
    int     rv_cyc;
    int     wait_cnt;
    longint si;
    longint sq;
    longint sd;
    longint exp_dc;
    n        = (l2n > LOG2N_MAX) ? LOG2N_MAX : l2n;
    need     = 1 << n;
    last_cap = -100;
    rv_cyc   = -1;
    si = 0; sq = 0; sd = 0;
    for (int k = 0; k < need; k++) begin
      si += longint'(samp_q[k]) * longint'(cos_q[k]);
      sq += longint'(samp_q[k]) * longint'(sin_q[k]);
      sd += longint'(samp_q[k]);
    end
    start_acq(l2n);
    check_output({tag, "_busy"}, bus.busy, 1);
    for (int k = 0; k < samp_q.size(); k++) begin
      bus.sample_valid = 1'b1;
      bus.sample       = ADC_W'(samp_q[k]);
      bus.cos_ref      = REF_W'(cos_q[k]);
      bus.sin_ref      = REF_W'(sin_q[k]);
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
      if (k == need - 1) last_cap = cyc;
      if (bus.result_valid && rv_cyc < 0) rv_cyc = cyc;
      if (gapped) begin
        if (poke_start && k == 2) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (bus.result_valid && rv_cyc < 0) rv_cyc = cyc;
      end
    end
    wait_cnt = 0;
    while (rv_cyc < 0 && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
      if (bus.result_valid) rv_cyc = cyc;
    end
    check_output({tag, "_latency"}, rv_cyc - last_cap, 3);
    check_output({tag, "_i_avg"}, bus.i_avg, floor_avg(si, n));
    check_output({tag, "_q_avg"}, bus.q_avg, floor_avg(sq, n));
`ifdef AC_LOCKIN_DC_EN
    exp_dc = floor_avg(sd, n);
`else
    exp_dc = 0;
`endif
    check_output({tag, "_dc_avg"}, bus.dc_avg, exp_dc);
    check_output({tag, "_done_busy"}, bus.busy, 0);
  endtask

  initial begin
    logic signed [ADC_W+REF_W-1:0] held_i;
    logic signed [ADC_W+REF_W-1:0] held_q;
    int l2n;

    bus.start = 1'b0; bus.log2n = '0; bus.sample_valid = 1'b0;
    bus.sample = '0; bus.cos_ref = '0; bus.sin_ref = '0; bus.result_ready = 1'b0;

    // Reset values.
    #12;
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_rv", bus.result_valid, 0);
    check_output("rst_i", bus.i_avg, 0);
    check_output("rst_q", bus.q_avg, 0);
    check_output("rst_dc", bus.dc_avg, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an acquisition.
    start_acq(2);
    for (int k = 0; k < 2; k++) begin
      bus.sample_valid = 1'b1; bus.sample = 12'sd100;
      bus.cos_ref = 16'sd16384; bus.sin_ref = 16'sd0;
      @(posedge clk); #1;
    end
    bus.sample_valid = 1'b0;
    check_output("mid_acq_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_output("abort_busy", bus.busy, 0);
    check_output("abort_rv", bus.result_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic run after reset.
    clear_queues();
    fill_const(4, 100, 16384, 0);
    apply_stimulus("basic", 2, 1'b0, 1'b0);
    check_output("basic_i_const", bus.i_avg, 1638400);
    consume("basic");

    // Floor rounding of a negative average.
    clear_queues();
    fill_const(1, -1, 1, -1);
    fill_const(1, 0, 1, -1);
    apply_stimulus("floor", 1, 1'b0, 1'b0);
    check_output("floor_i_const", bus.i_avg, -1);
    consume("floor");

    // Gapped valids, surplus pulses and a stray start during ACQ.
    clear_queues();
    fill_random(12);
    apply_stimulus("gapped", 3, 1'b1, 1'b1);

    // Held results while the consumer stalls, with a start pulse in DONE.
    held_i = bus.i_avg;
    held_q = bus.q_avg;
    for (int k = 0; k < 10; k++) begin
      bus.start = (k == 4);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_output("hold_rv", bus.result_valid, 1);
      check_output("hold_i", bus.i_avg, held_i);
    end
    check_output("hold_q", bus.q_avg, held_q);
    consume("gapped");
    check_output("post_consume_i", bus.i_avg, held_i);

    // Randomized runs; the start inside each verifies IDLE accepts it.
    for (int r = 0; r < 4; r++) begin
      l2n = int'($urandom_range(4));
      clear_queues();
      fill_random((1 << l2n) + int'($urandom_range(2)));
      apply_stimulus($sformatf("rand%0d", r), l2n, 1'b0, 1'b0);
      consume($sformatf("rand%0d", r));
    end

    // Clamped exponent with full-scale input.
    clear_queues();
    fill_const(1 << LOG2N_MAX, -2048, -32768, 32767);
    apply_stimulus("fullscale", 31, 1'b0, 1'b0);
    check_output("fullscale_i_const", bus.i_avg, 67108864);
    consume("fullscale");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
